fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RV32I core. It owns the program counter, drives the word address into the combinational instruction memory, and buffers each returned instruction with its PC in a small FIFO. It presents instructions to decode over a valid/ready handshake, and accepts PC redirects from execute for branches, jumps and jalr. Misaligned redirect targets are reported as a flagged bubble rather than fetched.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FIFO_DEPTH, 2: instruction buffer entries (power of two, ≥2).
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- redirect_valid_i  in  1  execute requests a PC change this cycle.
- redirect_pc_i  in  32  new PC target; sampled only when redirect_valid_i=1.
- imem_addr_o  out  32  byte address to the instruction memory; equals pc_q.
- imem_inst_i  in  32  instruction word returned combinationally for imem_addr_o.
- inst_valid_o  out  1  FIFO head holds an instruction.
- inst_ready_i  in  1  decode accepts the head this cycle.
- inst_o  out  32  head instruction.
- inst_pc_o  out  32  PC of the head instruction.
- inst_err_o  out  1  head entry is a misaligned-target marker.

## Operation
- pc_q register; imem_addr_o = pc_q at all times, including reset.
- FSM states:
  - FS_RUN: normal fetch.
  - FS_ERR: emit the misalign marker.
  - FS_HALT: fetch stopped until the next redirect.
- pop = inst_valid_o & inst_ready_i.
- push_ok = (count < FIFO_DEPTH) | pop.
- FS_RUN behaviour, no redirect, push_ok:
  - Push {pc_q, imem_inst_i, err=0}.
  - pc_q <= pc_q + 32'd4, wrapping mod 2^32.
  - If push_ok=0, pc_q holds and nothing is pushed.
- FS_ERR behaviour, no redirect, push_ok:
  - Push {pc_q, NOP (32'h0000_0013), err=1}.
  - Go to FS_HALT; pc_q holds.
- FS_HALT: no push, pc_q holds.
- Redirect has priority over everything in every state:
  - FIFO count cleared.
  - No push that cycle.
  - pc_q <= redirect_pc_i.
  - Next state is FS_ERR if redirect_pc_i[1:0] != 0, otherwise FS_RUN.
- Pop in the same cycle as a redirect:
  - The transfer completes normally; decode keeps that instruction.
  - All remaining entries are discarded.
- Pop and push in the same cycle when the FIFO is full: both occur and count is unchanged.
- When the FIFO is empty, inst_o, inst_pc_o and inst_err_o drive 0.

## Timing
- Reset values:
  - pc_q = RESET_PC; state FS_RUN; count 0.
  - inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, inst_err_o = 0.
  - imem_addr_o = RESET_PC.
- First instruction after reset release: pushed on the first rising edge, so inst_valid_o=1 in cycle 1.
- Redirect asserted in cycle N:
  - imem_addr_o = target in cycle N+1.
  - Target instruction is valid at the outputs in cycle N+2.
  - Redirect penalty is 2 cycles.
- Steady state with inst_ready_i held at 1: one instruction per cycle, no bubbles.
- Decode stall (inst_ready_i=0):
  - The FIFO fills in FIFO_DEPTH cycles, then pc_q freezes.
  - The head is stable until it is accepted.
- Asynchronous reset mid-operation: all state returns to reset values immediately; no partial push survives.

## Structure
- Shared package fetch_pkg:
  - NOP_INST = 32'h0000_0013.
  - fetch_state_e {FS_RUN, FS_ERR, FS_HALT}.
  - fetch_entry_t packed struct {pc[31:0], inst[31:0], err}.
- Sub-module fetch_fifo:
  - Parameterised depth; push, pop and flush inputs.
  - Flush overrides push.
  - Circular read/write pointers plus a count.
- fetch_unit holds pc_q, the FSM and the next-PC logic, and instantiates fetch_fifo.

## Test plan
- Reset release with RESET_PC=0, memory words i = 32'h1000_0000+i, inst_ready_i=1 -> inst_pc_o sequence 0,4,8,C with inst_o matching, one instruction per cycle starting at cycle 1.
- inst_ready_i=0 for 5 cycles after reset -> inst_valid_o=1 and the FIFO holds PCs 0 and 4; imem_addr_o frozen at 8; release -> 0,4,8 delivered with no gap or duplicate.
- Redirect to 32'h0000_0100 in cycle N while the FIFO is full -> FIFO flushed, imem_addr_o=0x100 in N+1, inst_pc_o=0x100 valid in N+2, old entries never appear.
- Redirect to 32'h0000_0102 -> exactly one entry {pc=0x102, inst=0x00000013, err=1}, then inst_valid_o=0 indefinitely; a later redirect to 0x200 resumes normal fetch.
- Pop and redirect in the same cycle -> the popped entry is transferred once and the next valid PC is the target.
- rst_i pulsed asynchronously mid-stream -> outputs return to zero, valid deasserts, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
//   NOP_INST      : word delivered with a misaligned-target marker
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one buffered fetch result {pc, inst, err}
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_RUN,   // normal sequential fetch
    FS_ERR,   // emit one misalign marker entry
    FS_HALT   // fetch stopped until the next redirect
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  // RV32I instructions are word aligned; any low bit set is a bad target.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch entries.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write wdata_i at the tail (ignored on flush or when full
//                  without a simultaneous pop)
//   pop_i        : drop the head (ignored when empty)
//   flush_i      : discard all entries; overrides push_i
//   wdata_i      : entry to write
//   rdata_o      : head entry, all zero when empty
//   valid_o      : buffer holds at least one entry
//   count_o      : number of entries held
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_eff, push_eff;

  assign pop_eff  = pop_i && (count_q != '0);
  // A full buffer can still take a write when the head leaves this cycle.
  assign push_eff = push_i && !flush_i && ((count_q != CW'(DEPTH)) || pop_eff);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by the count.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   redirect_valid_i/pc : PC change request from execute (highest priority)
//   imem_addr_o         : byte address to combinational instruction memory
//   imem_inst_i         : instruction word at imem_addr_o
//   inst_valid_o/ready_i: valid/ready handshake towards decode
//   inst_o, inst_pc_o   : head instruction and its PC (zero when empty)
//   inst_err_o          : head is a misaligned-target marker
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          push, pop, push_ok, flush;
  fetch_entry_t  push_entry, head_entry;
  logic [CW-1:0] count;

  assign pop     = inst_valid_o && inst_ready_i;
  assign push_ok = (count < CW'(FIFO_DEPTH)) || pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '{pc: pc_q, inst: imem_inst_i, err: 1'b0};

    if (redirect_valid_i) begin
      // A pop this cycle still completes at decode; only the rest is dropped.
      flush   = 1'b1;
      pc_d    = redirect_pc_i;
      state_d = is_misaligned(redirect_pc_i) ? FS_ERR : FS_RUN;
    end else begin
      case (state_q)
        FS_RUN: begin
          if (push_ok) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        FS_ERR: begin
          // The bad target is never sent to memory as a fetch; a NOP stands in.
          if (push_ok) begin
            push       = 1'b1;
            push_entry = '{pc: pc_q, inst: NOP_INST, err: 1'b1};
            state_d    = FS_HALT;
          end
        end
        default: ;  // FS_HALT: wait for a redirect
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .valid_o (inst_valid_o),
    .count_o (count)
  );

  assign imem_addr_o = pc_q;
  assign inst_o      = head_entry.inst;
  assign inst_pc_o   = head_entry.pc;
  assign inst_err_o  = head_entry.err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory word i holds 0x1000_0000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_inst = mem_word(imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_inst_i      (imem_inst),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_err_o       (inst_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          mmode;   // 0 fetching, 1 marker owed, 2 stopped

  task automatic model_reset();
    mq.delete();
    mpc   = 32'h0;
    mmode = 0;
  endtask

  task automatic model_step();
    bit   pop;
    ent_t e;
    pop = (mq.size() != 0) && inst_ready;
    if (redirect_valid) begin
      mq.delete();
      mpc   = redirect_pc;
      mmode = (redirect_pc[1:0] != 2'b00) ? 1 : 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        if (mmode == 0) begin
          e.pc = mpc; e.inst = mem_word(mpc); e.err = 1'b0;
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end else if (mmode == 1) begin
          e.pc = mpc; e.inst = NOP; e.err = 1'b1;
          mq.push_back(e);
          mmode = 2;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
      chk("m_addr", imem_addr, mpc);
      if (mq.size() != 0) begin
        chk("m_inst", inst, mq[0].inst);
        chk("m_pc", inst_pc, mq[0].pc);
        chk("m_err", {31'b0, inst_err}, {31'b0, mq[0].err});
      end else begin
        chk("m_inst0", inst, 32'h0);
        chk("m_pc0", inst_pc, 32'h0);
        chk("m_err0", {31'b0, inst_err}, 32'h0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_err", {31'b0, inst_err}, 32'h0);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;

    // Streaming after reset: one instruction per cycle from cycle 1.
    inst_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_valid", {31'b0, inst_valid}, 32'h1);
      chk("stream_pc", inst_pc, 32'(4 * k));
      chk("stream_inst", inst, 32'h1000_0000 + 32'(k));
    end

    // Decode stall: buffer fills, PC freezes, then drains in order.
    inst_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("stall_valid", {31'b0, inst_valid}, 32'h1);
    chk("stall_head", inst_pc, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    inst_ready = 1'b1;
    tick();
    chk("drain_pc4", inst_pc, 32'h4);
    tick();
    chk("drain_pc8", inst_pc, 32'h8);

    // Redirect while full.
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    redirect_to(32'h0000_0100);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_flush", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("redir_valid", {31'b0, inst_valid}, 32'h1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_inst", inst, 32'h1000_0040);

    // Misaligned redirect: single marker, then silence, then recovery.
    inst_ready = 1'b1;
    redirect_to(32'h0000_0102);
    chk("mis_addr", imem_addr, 32'h102);
    tick();
    chk("mis_valid", {31'b0, inst_valid}, 32'h1);
    chk("mis_pc", inst_pc, 32'h102);
    chk("mis_inst", inst, 32'h13);
    chk("mis_err", {31'b0, inst_err}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_valid", {31'b0, inst_valid}, 32'h0);
      chk("halt_addr", imem_addr, 32'h102);
    end
    redirect_to(32'h0000_0200);
    tick();
    chk("resume_pc", inst_pc, 32'h200);
    chk("resume_inst", inst, 32'h1000_0080);
    chk("resume_err", {31'b0, inst_err}, 32'h0);

    // Pop coinciding with a redirect.
    tick();
    tick();
    chk("pr_head_valid", {31'b0, inst_valid}, 32'h1);
    chk("pr_head_pc", inst_pc, 32'h208);
    redirect_to(32'h0000_0300);
    chk("pr_flush", {31'b0, inst_valid}, 32'h0);
    tick();
    chk("pr_target", inst_pc, 32'h300);

    // Asynchronous reset pulse between clock edges.
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_pc", inst_pc, 32'h0);
    #1 rst = 1'b0;
    tick();
    chk("arst_restart", inst_pc, 32'h0);
    chk("arst_restart_v", {31'b0, inst_valid}, 32'h1);

    // Randomised traffic, including wrap-around targets.
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
